// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the button input controller.
package btn_pkg;

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} btn_state_t;

    // Counter width sized from the largest count it must hold, with a spare bit for saturation.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/btn_fsm.sv
// Per-button debounce FSM with press/release pulses and auto-repeat; acts only on sample ticks.
module btn_fsm
    import btn_pkg::*;
#(
    parameter int STABLE_TICKS = 10,
    parameter int REPEAT_DELAY = 300,
    parameter int REPEAT_RATE  = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic sync,
    output logic level,
    output logic press,
    output logic rel,
    output logic rep
);

    localparam int CW = cnt_width(STABLE_TICKS, REPEAT_DELAY, REPEAT_RATE);
    localparam logic [CW-1:0] ST  = CW'(STABLE_TICKS);
    localparam logic [CW-1:0] RD  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RLD = CW'(REPEAT_DELAY - REPEAT_RATE);

    btn_state_t    state;
    logic [CW-1:0] cnt, rpt;
    logic [CW-1:0] cnt_inc, rpt_inc;

    assign cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);
    assign rpt_inc = (rpt == '1) ? rpt : rpt + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            rpt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
            rep   <= 1'b0;
        end else begin
            press <= 1'b0;
            rel   <= 1'b0;
            rep   <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE: if (sync) begin
                        if (STABLE_TICKS <= 1) begin
                            state <= HELD;
                            level <= 1'b1;
                            press <= 1'b1;
                            cnt   <= '0;
                            rpt   <= '0;
                        end else begin
                            state <= PRESS_WAIT;
                            cnt   <= CW'(1);
                        end
                    end
                    PRESS_WAIT: begin
                        if (!sync) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt_inc >= ST) begin
                            state <= HELD;
                            level <= 1'b1;
                            press <= 1'b1;
                            cnt   <= '0;
                            rpt   <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    HELD, RELEASE_WAIT: begin
                        if (!sync && ((state == HELD && STABLE_TICKS <= 1) ||
                                      (state == RELEASE_WAIT && cnt_inc >= ST))) begin
                            state <= IDLE;
                            level <= 1'b0;
                            rel   <= 1'b1;
                            cnt   <= '0;
                            rpt   <= '0;
                        end else begin
                            // Repeat cadence keeps running through a short release glitch.
                            if (rpt_inc >= RD) begin
                                rep <= 1'b1;
                                rpt <= RLD;
                            end else begin
                                rpt <= rpt_inc;
                            end
                            if (state == HELD && !sync) begin
                                state <= RELEASE_WAIT;
                                cnt   <= CW'(1);
                            end else if (state == RELEASE_WAIT && sync) begin
                                state <= HELD;
                                cnt   <= '0;
                            end else if (state == RELEASE_WAIT) begin
                                cnt <= cnt_inc;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/btn_input_ctrl.sv
// Button input controller: 3-flop synchronizers, shared tick prescaler, one debounce FSM per button.
module btn_input_ctrl
    import btn_pkg::*;
#(
    parameter int NUM_BTN      = 4,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 10,
    parameter int REPEAT_DELAY = 300,
    parameter int REPEAT_RATE  = 50
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat
);

    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0]               pre;
    logic                        tick;
    logic [2:0][NUM_BTN-1:0]     sync_q;

    assign tick = (pre == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre    <= '0;
            sync_q <= '0;
        end else begin
            pre    <= tick ? '0 : pre + PW'(1);
            sync_q <= {sync_q[1:0], btn_raw};
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_fsm #(
            .STABLE_TICKS(STABLE_TICKS),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_fsm (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (tick),
            .sync (sync_q[2][g]),
            .level(btn_level[g]),
            .press(btn_press[g]),
            .rel  (btn_release[g]),
            .rep  (btn_repeat[g])
        );
    end

endmodule

// File: tb/tb_btn_input_ctrl.sv
// Directed bench for btn_input_ctrl with TICK_DIV=4, STABLE_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2.
module tb_btn_input_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] btn_raw = 4'b0;
    logic [3:0] btn_level, btn_press, btn_release, btn_repeat;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pc[4], rc[4], ec[4];
    logic [3:0] overlap = 4'b0;

    btn_input_ctrl #(
        .NUM_BTN(4), .TICK_DIV(4), .STABLE_TICKS(3), .REPEAT_DELAY(5), .REPEAT_RATE(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat)
    );

    always #5 clk = ~clk;

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        for (int b = 0; b < 4; b++) begin
            pc[b] = 0; rc[b] = 0; ec[b] = 0;
        end
    endtask

    // One clock: sample 1 ns after the edge and tally pulses.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int b = 0; b < 4; b++) begin
            pc[b] += int'(btn_press[b]);
            rc[b] += int'(btn_release[b]);
            ec[b] += int'(btn_repeat[b]);
        end
        overlap = overlap | (btn_press & btn_repeat) | (btn_release & (btn_press | btn_repeat));
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        cyc = 0;
        clr_counts();
    endtask

    task automatic do_reset(input string tag);
        rst_n   = 1'b0;
        btn_raw = 4'b0;
        #1;
        chk4({tag, "_level"}, btn_level, 4'b0);
        chk4({tag, "_pulses"}, btn_press | btn_release | btn_repeat, 4'b0);
        release_reset();
    endtask

    initial begin
        #3;
        do_reset("rst0");

        // Clean press on 0 and 3 together, long hold, then release of 0.
        step();
        btn_raw = 4'b1001;
        run_to(15);
        chk4("A_pre_press", btn_press, 4'b0000);
        chk4("A_pre_level", btn_level, 4'b0000);
        run_to(16);
        chk4("A_press_sim", btn_press, 4'b1001);
        chk4("A_level_up", btn_level, 4'b1001);
        chk4("A_no_rep_at_press", btn_repeat, 4'b0000);
        run_to(17);
        chk4("A_press_1cyc", btn_press, 4'b0000);
        run_to(35);
        chk4("A_no_rep_early", btn_repeat, 4'b0000);
        run_to(36);
        chk4("A_rep_first", btn_repeat, 4'b1001);
        run_to(37);
        chk4("A_rep_1cyc", btn_repeat, 4'b0000);
        run_to(40);
        chk4("A_no_rep_40", btn_repeat, 4'b0000);
        run_to(44);
        chk4("A_rep_second", btn_repeat, 4'b1001);
        run_to(96);
        chkn("A_press_count", pc[0], 1);
        chkn("A_rep_count", ec[0], 8);
        chk4("A_level_held", btn_level, 4'b1001);
        run_to(97);
        btn_raw = 4'b1000;
        run_to(111);
        chk4("A_no_rel_early", btn_release, 4'b0000);
        chk4("A_level_before_rel", btn_level, 4'b1001);
        run_to(112);
        chk4("A_release", btn_release, 4'b0001);
        chk4("A_level_down", btn_level, 4'b1000);
        chk4("A_no_rep_at_rel", btn_repeat, 4'b0000);
        run_to(113);
        chk4("A_rel_1cyc", btn_release, 4'b0000);
        run_to(140);
        chkn("A_rep_stops", ec[0], 10);
        chkn("A_rel_count", rc[0], 1);
        chkn("A_btn3_no_rel", rc[3], 0);
        chkn("A_btn3_rep_count", ec[3], 14);

        // Bounce on 1, release glitch on 2.
        do_reset("rst1");
        step();
        btn_raw = 4'b0110;
        run_to(9);
        btn_raw[1] = 1'b0;
        run_to(16);
        chk4("B_bounce_no_press", btn_press, 4'b0100);
        run_to(17);
        btn_raw[1] = 1'b1;
        run_to(31);
        chk4("B_press_not_early", btn_press, 4'b0000);
        run_to(32);
        chk4("B_press_after_bounce", btn_press, 4'b0010);
        run_to(36);
        chk4("B_rep_36", btn_repeat, 4'b0100);
        run_to(37);
        btn_raw[2] = 1'b0;
        run_to(44);
        chk4("B_rep_44", btn_repeat, 4'b0100);
        run_to(45);
        btn_raw[2] = 1'b1;
        run_to(48);
        chk4("B_level_glitch", btn_level, 4'b0110);
        run_to(52);
        chk4("B_rep_52", btn_repeat, 4'b0110);
        run_to(70);
        chkn("B_press1_count", pc[1], 1);
        chkn("B_rel1_count", rc[1], 0);
        chkn("B_rel2_count", rc[2], 0);
        chkn("B_rep2_count", ec[2], 5);
        chk4("B_level_end", btn_level, 4'b0110);

        // Reset while button 0 is mid-debounce and button 3 is held.
        do_reset("rst2");
        step();
        btn_raw = 4'b1000;
        run_to(5);
        btn_raw = 4'b1001;
        run_to(16);
        chk4("C_btn3_press", btn_press, 4'b1000);
        run_to(17);
        chk4("C_level_before_rst", btn_level, 4'b1000);
        #2;
        rst_n = 1'b0;
        #1;
        chk4("C_rst_level", btn_level, 4'b0000);
        chk4("C_rst_pulses", btn_press | btn_release | btn_repeat, 4'b0000);
        release_reset();
        run_to(11);
        chk4("C_no_early_press", btn_press, 4'b0000);
        chk4("C_level_low", btn_level, 4'b0000);
        run_to(12);
        chk4("C_press_after_rst", btn_press, 4'b1001);
        chk4("C_level_after_rst", btn_level, 4'b1001);
        run_to(20);
        chkn("C_press_count", pc[0], 1);

        chk4("no_pulse_overlap", overlap, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_input_ctrl.md
# btn_input_ctrl

Input controller for the Pong player buttons. It synchronizes NUM_BTN raw pushbutton lines into the clock domain and filters each one with a counter-based debounce state machine. All filters share a single sampling-tick prescaler. Each button produces a clean level, one-cycle press and release pulses, and an auto-repeat pulse stream that the paddle movement logic consumes.

## Interface
- NUM_BTN, 4: number of buttons (P1 up/down, P2 up/down).
- TICK_DIV, 100000: clk cycles per sample tick (1 ms at 100 MHz); minimum 2.
- STABLE_TICKS, 10: consecutive agreeing samples required to accept a level change; minimum 1.
- REPEAT_DELAY, 300: ticks from the press pulse to the first repeat pulse.
- REPEAT_RATE, 50: ticks between subsequent repeat pulses.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- btn_raw  in  NUM_BTN  raw asynchronous button inputs, active-high.
- btn_level  out  NUM_BTN  debounced level.
- btn_press  out  NUM_BTN  one-cycle pulse on an accepted 0→1 change.
- btn_release  out  NUM_BTN  one-cycle pulse on an accepted 1→0 change.
- btn_repeat  out  NUM_BTN  one-cycle auto-repeat pulse while held.

## Operation
- Synchronizer: 3 flops per bit; downstream logic sees only the third stage (sync).
- Prescaler: counter runs 0..TICK_DIV-1. tick is high for one cycle when the count equals TICK_DIV-1, then the counter wraps to 0.
- Per-button FSM, evaluated only on tick cycles. States:
  - IDLE (level 0): sync=1 → PRESS_WAIT, cnt=1. If STABLE_TICKS=1, go directly to HELD and pulse press.
  - PRESS_WAIT: sync=1 → cnt+1; when cnt reaches STABLE_TICKS → HELD and pulse press. sync=0 → IDLE, cnt=0. The bounce produces no pulse.
  - HELD (level 1): sync=0 → RELEASE_WAIT, cnt=1. rpt counter advances each tick.
  - RELEASE_WAIT: sync=0 → cnt+1; when cnt reaches STABLE_TICKS → IDLE, pulse release, clear rpt. sync=1 → HELD, cnt=0. rpt keeps advancing.
- Auto-repeat: rpt is cleared on entry to HELD.
  - First repeat pulse fires when rpt reaches REPEAT_DELAY.
  - Later pulses fire every REPEAT_RATE ticks after that. rpt reloads to REPEAT_DELAY-REPEAT_RATE on each pulse; it never free-wraps.
  - No repeat pulse fires in IDLE or PRESS_WAIT.
- Counter widths: $clog2(max param)+1. Counters saturate and must never wrap.
- Buttons are fully independent. Simultaneous events on different buttons all pulse in the same cycle.

## Timing
- Reset (rst_n low, any time, including mid-debounce): prescaler=0, all sync flops=0, all FSMs=IDLE, cnt=rpt=0. All outputs are 0 immediately, asynchronously.
- First tick occurs TICK_DIV cycles after rst_n deasserts.
- Registered outputs: pulses and level changes appear the cycle after the deciding tick.
  - btn_level changes in the same cycle as its press or release pulse.
- Pulse width is exactly 1 clk.
- Press-to-level latency: 3 sync cycles + up to TICK_DIV alignment + STABLE_TICKS ticks + 1 cycle.
- btn_press and btn_repeat are never high in the same cycle for one button. btn_release never coincides with either.

## Structure
- Shared package btn_pkg:
  - enum btn_state_t {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT}.
  - Counter-width localparam function.
- The prescaler and synchronizer live in the top module.
- Sub-module btn_fsm, instantiated NUM_BTN times via generate.
  - Inputs: clk, rst_n, tick, sync bit.
  - Outputs: level, press, release, repeat.

## Test plan
All scenarios use sim params TICK_DIV=4, STABLE_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2.
- Clean press of btn_raw[0] held for 20 ticks:
  - btn_press[0] pulses once, 3 ticks after sync rises.
  - btn_repeat[0] pulses at 5, 7, 9, … ticks after the press.
  - btn_level[0]=1 throughout.
- Bounce: btn_raw[1] high for 2 ticks, low, then high for 4 ticks → exactly one btn_press[1], 3 ticks after the second rise. No release pulse.
- Release glitch: held btn_raw[2] drops for 2 ticks → no release pulse, level stays 1, and the repeat cadence is unbroken.
- Simultaneous: btn_raw[0] and btn_raw[3] rise on the same cycle → both press pulses fire in the same cycle.
- Reset during PRESS_WAIT:
  - All outputs go to 0 within the reset cycle.
  - After release, with the button still high, the press pulse arrives STABLE_TICKS ticks after the first post-reset tick.
- Release after hold: btn_raw[0] low for 3 ticks → btn_release[0] fires one cycle with level→0, and no further repeat pulses occur.
